// File: rtl/parallel_packer.sv
// Serial-to-parallel I/Q packer: collects LANES signed samples into one vector,
// emits it with a one-cycle strobe and tracks its position within a frame of BLOCKS vectors.
module parallel_packer #(
    parameter int DATA_WIDTH = 9,
    parameter int LANES      = 16,
    parameter int BLOCKS     = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         din_valid,
    input  logic signed [DATA_WIDTH-1:0] din_i,
    input  logic signed [DATA_WIDTH-1:0] din_q,
    input  logic                         flush,
    output logic                         dout_valid,
    output logic signed [DATA_WIDTH-1:0] dout_i [0:LANES-1],
    output logic signed [DATA_WIDTH-1:0] dout_q [0:LANES-1],
    output logic [$clog2(BLOCKS)-1:0]    blk_idx,
    output logic                         frame_last,
    output logic                         busy
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BW = $clog2(BLOCKS);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                         state_r;
    state_t                         state_nxt_s;
    logic [LW-1:0]                  lane_cnt_r;
    logic [LW-1:0]                  lane_cnt_nxt_s;
    logic [BW-1:0]                  blk_cnt_r;
    logic [BW-1:0]                  blk_cnt_nxt_s;
    logic signed [DATA_WIDTH-1:0]   stage_i_r [0:LANES-1];
    logic signed [DATA_WIDTH-1:0]   stage_q_r [0:LANES-1];
    logic signed [DATA_WIDTH-1:0]   stage_i_s [0:LANES-1];
    logic signed [DATA_WIDTH-1:0]   stage_q_s [0:LANES-1];
    logic                           lane_last_s;
    logic                           blk_last_s;
    logic                           emit_s;
    logic                           frame_end_s;

    // Staging view with the current sample already written, so an emitting cycle includes it
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            stage_i_s[k] = (din_valid && (lane_cnt_r == LW'(k))) ? din_i : stage_i_r[k];
            stage_q_s[k] = (din_valid && (lane_cnt_r == LW'(k))) ? din_q : stage_q_r[k];
        end
    end

    // Next-state logic: a flush applies after any same-cycle sample has been accepted
    always_comb begin
        lane_last_s    = (lane_cnt_r == LW'(LANES - 1));
        blk_last_s     = (blk_cnt_r == BW'(BLOCKS - 1));
        emit_s         = (din_valid && lane_last_s) ||
                         (flush && (din_valid || (lane_cnt_r != '0)));
        frame_end_s    = emit_s && (flush || blk_last_s);
        lane_cnt_nxt_s = lane_cnt_r;
        blk_cnt_nxt_s  = blk_cnt_r;
        if (emit_s) begin
            lane_cnt_nxt_s = '0;
            blk_cnt_nxt_s  = frame_end_s ? '0 : (blk_cnt_r + BW'(1));
        end else if (flush) begin
            lane_cnt_nxt_s = '0;
            blk_cnt_nxt_s  = '0;
        end else if (din_valid) begin
            lane_cnt_nxt_s = lane_cnt_r + LW'(1);
            blk_cnt_nxt_s  = blk_cnt_r;
        end else begin
            lane_cnt_nxt_s = lane_cnt_r;
            blk_cnt_nxt_s  = blk_cnt_r;
        end
        if ((lane_cnt_nxt_s == '0) && (blk_cnt_nxt_s == '0)) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = FILL;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            lane_cnt_r <= '0;
            blk_cnt_r  <= '0;
        end else begin
            state_r    <= state_nxt_s;
            lane_cnt_r <= lane_cnt_nxt_s;
            blk_cnt_r  <= blk_cnt_nxt_s;
        end
    end

    // Staging lanes: cleared on emission so a later flush leaves unfilled lanes at zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < LANES; k++) begin
                stage_i_r[k] <= '0;
                stage_q_r[k] <= '0;
            end
        end else if (emit_s) begin
            for (int k = 0; k < LANES; k++) begin
                stage_i_r[k] <= '0;
                stage_q_r[k] <= '0;
            end
        end else begin
            stage_i_r <= stage_i_s;
            stage_q_r <= stage_q_s;
        end
    end

    // Output vector and index hold their last emitted value between strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < LANES; k++) begin
                dout_i[k] <= '0;
                dout_q[k] <= '0;
            end
            blk_idx <= '0;
        end else if (emit_s) begin
            dout_i  <= stage_i_s;
            dout_q  <= stage_q_s;
            blk_idx <= blk_cnt_r;
        end else begin
            dout_i  <= dout_i;
            dout_q  <= dout_q;
            blk_idx <= blk_idx;
        end
    end

    // One-cycle strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_valid <= 1'b0;
            frame_last <= 1'b0;
        end else begin
            dout_valid <= emit_s;
            frame_last <= frame_end_s;
        end
    end

    assign busy = (state_r == FILL);

endmodule

// File: tb/tb_parallel_packer.sv
// Directed self-checking bench for parallel_packer with hand-computed expectations.
module tb_parallel_packer;

    localparam int DW = 9;
    localparam int L  = 16;
    localparam int B  = 16;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 din_valid;
    logic                 flush;
    logic signed [DW-1:0] din_i;
    logic signed [DW-1:0] din_q;
    logic                 dout_valid;
    logic signed [DW-1:0] dout_i [0:L-1];
    logic signed [DW-1:0] dout_q [0:L-1];
    logic [3:0]           blk_idx;
    logic                 frame_last;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    parallel_packer #(.DATA_WIDTH(DW), .LANES(L), .BLOCKS(B)) dut (
        .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
        .flush(flush), .dout_valid(dout_valid), .dout_i(dout_i), .dout_q(dout_q),
        .blk_idx(blk_idx), .frame_last(frame_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        din_valid = 1'b0;
        flush     = 1'b0;
        din_i     = '0;
        din_q     = '0;
    endtask

    task automatic send(input int vi, input int vq, input logic fl);
        din_valid = 1'b1;
        flush     = fl;
        din_i     = DW'(vi);
        din_q     = DW'(vq);
        tick();
        idle_in();
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        idle_in();
        tick();
        tick();
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", dout_valid); end
        total++; if (frame_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%0b want=0", frame_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (blk_idx !== 4'd0) begin bad++; $display("FAIL reset_blk got=%0d want=0", blk_idx); end
        for (int k = 0; k < L; k++) begin
            total++;
            if (dout_i[k] !== 9'sd0 || dout_q[k] !== 9'sd0) begin
                bad++; $display("FAIL reset_lane%0d got=%0d/%0d want=0/0", k, dout_i[k], dout_q[k]);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_continuous;
        logic signed [DW-1:0] ei, eq;
        for (int k = 1; k <= 16; k++) begin
            send(k, -k, 1'b0);
            if (k < 16) begin
                total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL cont_early k=%0d got=%0b want=0", k, dout_valid); end
            end else begin
                total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL cont_valid got=%0b want=1", dout_valid); end
            end
        end
        for (int j = 0; j < L; j++) begin
            ei = DW'(j + 1);
            eq = DW'(-(j + 1));
            total++;
            if (dout_i[j] !== ei || dout_q[j] !== eq) begin
                bad++; $display("FAIL cont_lane%0d got=%0d/%0d want=%0d/%0d", j, dout_i[j], dout_q[j], ei, eq);
            end
        end
        total++; if (blk_idx !== 4'd0) begin bad++; $display("FAIL cont_blk got=%0d want=0", blk_idx); end
        total++; if (frame_last !== 1'b0) begin bad++; $display("FAIL cont_last got=%0b want=0", frame_last); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL cont_busy got=%0b want=1", busy); end
        tick();
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL cont_oneshot got=%0b want=0", dout_valid); end
        total++; if (dout_i[15] !== 9'sd16) begin bad++; $display("FAIL cont_hold got=%0d want=16", dout_i[15]); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL flush_empty_valid got=%0b want=0", dout_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_empty_busy got=%0b want=0", busy); end
    endtask

    task automatic test_full_frame;
        int pulses = 0;
        logic exp_v;
        logic signed [DW-1:0] ei, eq;
        for (int t = 0; t < 256; t++) begin
            din_valid = 1'b1;
            din_i = DW'(t - 128);
            din_q = DW'(127 - t);
            tick();
            exp_v = ((t % 16) == 15);
            total++; if (dout_valid !== exp_v) begin bad++; $display("FAIL frame_valid t=%0d got=%0b want=%0b", t, dout_valid, exp_v); end
            if (exp_v) begin
                pulses++;
                ei = DW'(t - 15 - 128);
                eq = DW'(127 - t);
                total++; if (blk_idx !== 4'(t / 16)) begin bad++; $display("FAIL frame_blk t=%0d got=%0d want=%0d", t, blk_idx, t / 16); end
                total++; if (frame_last !== ((t / 16) == 15)) begin bad++; $display("FAIL frame_last t=%0d got=%0b", t, frame_last); end
                total++; if (dout_i[0] !== ei || dout_q[15] !== eq) begin
                    bad++; $display("FAIL frame_data t=%0d got=%0d/%0d want=%0d/%0d", t, dout_i[0], dout_q[15], ei, eq);
                end
            end
        end
        idle_in();
        tick();
        total++; if (pulses != 16) begin bad++; $display("FAIL frame_pulses got=%0d want=16", pulses); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy got=%0b want=0", busy); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL frame_after got=%0b want=0", dout_valid); end
    endtask

    task automatic test_partial_flush;
        logic signed [DW-1:0] ei, eq;
        for (int j = 0; j < 5; j++) begin
            send(7 + j, -(7 + j), 1'b0);
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL part_busy_fill got=%0b want=1", busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL part_valid got=%0b want=1", dout_valid); end
        total++; if (frame_last !== 1'b1) begin bad++; $display("FAIL part_last got=%0b want=1", frame_last); end
        total++; if (blk_idx !== 4'd0) begin bad++; $display("FAIL part_blk got=%0d want=0", blk_idx); end
        for (int j = 0; j < L; j++) begin
            ei = (j < 5) ? DW'(7 + j) : 9'sd0;
            eq = (j < 5) ? DW'(-(7 + j)) : 9'sd0;
            total++;
            if (dout_i[j] !== ei || dout_q[j] !== eq) begin
                bad++; $display("FAIL part_lane%0d got=%0d/%0d want=%0d/%0d", j, dout_i[j], dout_q[j], ei, eq);
            end
        end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL part_busy got=%0b want=0", busy); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL part_oneshot got=%0b want=0", dout_valid); end
    endtask

    task automatic test_simultaneous;
        for (int j = 0; j < 16; j++) send(100 + j, j, 1'b0);
        for (int j = 0; j < 15; j++) send(30 + j, -j, 1'b0);
        send(45, -45, 1'b1);
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL sim_valid got=%0b want=1", dout_valid); end
        total++; if (frame_last !== 1'b1) begin bad++; $display("FAIL sim_last got=%0b want=1", frame_last); end
        total++; if (blk_idx !== 4'd1) begin bad++; $display("FAIL sim_blk got=%0d want=1", blk_idx); end
        total++; if (dout_i[0] !== 9'sd30 || dout_i[15] !== 9'sd45) begin
            bad++; $display("FAIL sim_data got=%0d/%0d want=30/45", dout_i[0], dout_i[15]);
        end
        tick();
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL sim_single got=%0b want=0", dout_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sim_busy got=%0b want=0", busy); end
        for (int j = 0; j < 16; j++) send(60 + j, 0, 1'b0);
        total++; if (dout_valid !== 1'b1 || blk_idx !== 4'd0 || frame_last !== 1'b0) begin
            bad++; $display("FAIL sim_next got=%0b/%0d/%0b want=1/0/0", dout_valid, blk_idx, frame_last);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL sim_flush0 got=%0b want=0", dout_valid); end
        send(77, 7, 1'b1);
        total++; if (dout_valid !== 1'b1 || frame_last !== 1'b1 || blk_idx !== 4'd0) begin
            bad++; $display("FAIL sim_lane0 got=%0b/%0b/%0d want=1/1/0", dout_valid, frame_last, blk_idx);
        end
        total++; if (dout_i[0] !== 9'sd77 || dout_i[1] !== 9'sd0) begin
            bad++; $display("FAIL sim_lane0_data got=%0d/%0d want=77/0", dout_i[0], dout_i[1]);
        end
    endtask

    task automatic test_gapped;
        logic signed [DW-1:0] ei;
        for (int j = 0; j < 16; j++) begin
            send(20 + j, -(20 + j), 1'b0);
            total++; if (dout_valid !== (j == 15)) begin bad++; $display("FAIL gap_valid j=%0d got=%0b", j, dout_valid); end
            if (j < 15) begin
                din_i = -9'sd1;
                din_q = -9'sd1;
                tick();
                total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL gap_idle j=%0d got=%0b want=0", j, dout_valid); end
            end
        end
        for (int j = 0; j < L; j++) begin
            ei = DW'(20 + j);
            total++; if (dout_i[j] !== ei) begin bad++; $display("FAIL gap_lane%0d got=%0d want=%0d", j, dout_i[j], ei); end
        end
        total++; if (blk_idx !== 4'd0) begin bad++; $display("FAIL gap_blk got=%0d want=0", blk_idx); end
    endtask

    task automatic test_reset_mid;
        for (int j = 0; j < 16; j++) send(90 + j, 1, 1'b0);
        total++; if (blk_idx !== 4'd1) begin bad++; $display("FAIL rst_pre_blk got=%0d want=1", blk_idx); end
        for (int j = 0; j < 9; j++) send(40 + j, 2, 1'b0);
        rstn = 1'b0;
        #1;
        total++; if (dout_i[0] !== 9'sd0 || dout_q[0] !== 9'sd0 || blk_idx !== 4'd0) begin
            bad++; $display("FAIL rst_async got=%0d/%0d/%0d want=0/0/0", dout_i[0], dout_q[0], blk_idx);
        end
        total++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0b/%0b want=0/0", busy, dout_valid); end
        din_valid = 1'b1;
        din_i = 9'sd5;
        repeat (2) tick();
        total++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_ignore got=%0b/%0b want=0/0", dout_valid, busy); end
        rstn = 1'b1;
        for (int j = 0; j < 16; j++) begin
            send(50 + j, -(50 + j), 1'b0);
            total++; if (dout_valid !== (j == 15)) begin bad++; $display("FAIL rst_valid j=%0d got=%0b", j, dout_valid); end
        end
        total++; if (blk_idx !== 4'd0) begin bad++; $display("FAIL rst_blk got=%0d want=0", blk_idx); end
        total++; if (dout_i[0] !== 9'sd50 || dout_i[15] !== 9'sd65) begin
            bad++; $display("FAIL rst_data got=%0d/%0d want=50/65", dout_i[0], dout_i[15]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_continuous();
        test_full_frame();
        test_partial_flush();
        test_simultaneous();
        test_gapped();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
